tdm_demux8: RTL and testbench

- Receiving end of an 8-channel time-division link: a transmitter steps an 8:1 mux select 0..7 and sends one sample per strobe.
- This block captures each strobed sample into the slot for the current channel and tracks the channel with a 3-bit counter.
- After the channel-7 sample it presents the whole frame in parallel, with a one-cycle valid pulse.
- It enforces frame alignment using a sync marker that accompanies channel 0, and flags alignment errors.

---
 rtl/tdm_demux8_pkg.sv | 24 ++
 rtl/tdm_demux8_demux1to8.sv | 24 ++
 rtl/tdm_demux8.sv | 135 +++++++++++++
 tb/tb_tdm_demux8.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux8_pkg
// Description : Shared constants, state encoding and slot-index helper for the
//               8-channel TDM receive demultiplexer.
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_demux8_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Lowest bit index of channel slot 'chan' in a packed frame of dw-bit samples
    function automatic int ch_lsb(input int chan, input int dw);
        return chan * dw;
    endfunction

endpackage : tdm_demux8_pkg
`default_nettype wire

// File: rtl/tdm_demux8_demux1to8.sv
`default_nettype none
// ============================================================================
// Module      : demux1to8
// Description : Combinational 3-to-8 one-hot decoder with enable; drives the
//               per-slot write enables of the frame shadow register.
// Revision    : 1.0 - initial release
// ============================================================================
module demux1to8
    import tdm_demux8_pkg::*;
(
    input  logic [SEL_W-1:0]  sel,
    input  logic              en,
    output logic [NUM_CH-1:0] onehot
);

    // One output line per select value, gated by the enable
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_line
            assign onehot[i] = en && (sel == SEL_W'(i));
        end
    endgenerate

endmodule : demux1to8
`default_nettype wire

// File: rtl/tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux8
// Description : Receive side of an 8-channel TDM link. Collects one strobed
//               sample per channel into a shadow register, publishes the full
//               frame with a one-cycle valid pulse, and checks alignment
//               against a sync marker that accompanies channel 0.
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux8
    import tdm_demux8_pkg::*;
#(
    parameter int DW = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 sync,
    input  logic [DW-1:0]        din,
    input  logic                 err_clr,
    output logic [SEL_W-1:0]     ch,
    output logic [NUM_CH*DW-1:0] dout,
    output logic                 dout_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NUM_CH - 1);

    state_e                state_q, state_d;
    logic [SEL_W-1:0]      ch_q, ch_d;
    logic [NUM_CH*DW-1:0]  shadow_q, shadow_d;
    logic [NUM_CH*DW-1:0]  dout_q, dout_d;
    logic                  valid_q, valid_d;
    logic                  err_q, err_d;

    logic                  wr_en;
    logic [SEL_W-1:0]      wr_sel;
    logic                  complete;
    logic                  err_set;
    logic [NUM_CH-1:0]     slot_we;

    // Frame FSM: decide the write slot, next channel, completion and errors
    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        wr_en    = 1'b0;
        wr_sel   = ch_q;
        complete = 1'b0;
        err_set  = 1'b0;
        if (en) begin
            case (state_q)
                IDLE: begin
                    // Non-sync strobes while unaligned are silently dropped
                    if (sync) begin
                        wr_en   = 1'b1;
                        wr_sel  = '0;
                        ch_d    = SEL_W'(1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (sync) begin
                        // Sync anywhere but channel 0 aborts the partial frame
                        // and restarts assembly with this sample as channel 0
                        err_set = (ch_q != '0);
                        wr_en   = 1'b1;
                        wr_sel  = '0;
                        ch_d    = SEL_W'(1);
                    end else if (ch_q == '0) begin
                        err_set = 1'b1;
                        state_d = IDLE;
                    end else begin
                        wr_en  = 1'b1;
                        wr_sel = ch_q;
                        if (ch_q == LAST_CH) begin
                            complete = 1'b1;
                            ch_d     = '0;
                        end else begin
                            ch_d = ch_q + SEL_W'(1);
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
        valid_d = complete;
        // A new error takes precedence over a simultaneous clear
        err_d   = err_set ? 1'b1 : (err_clr ? 1'b0 : err_q);
    end

    demux1to8 u_demux (
        .sel    (wr_sel),
        .en     (wr_en),
        .onehot (slot_we)
    );

    // Shadow slot writes; the output frame is the shadow including this sample
    always_comb begin
        shadow_d = shadow_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (slot_we[i]) begin
                shadow_d[ch_lsb(i, DW) +: DW] = din;
            end
        end
        dout_d = complete ? shadow_d : dout_q;
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            shadow_q <= '0;
            dout_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            shadow_q <= shadow_d;
            dout_q   <= dout_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    assign ch         = ch_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign frame_err  = err_q;
    assign busy       = (state_q == RUN);

endmodule : tdm_demux8
`default_nettype wire

// File: tb/tb_tdm_demux8.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux8
// Description : Self-checking bench for tdm_demux8 (DW=1) with a queue-based
//               reference model and directed frame sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       sync = 1'b0;
    logic [0:0] din = 1'b0;
    logic       err_clr = 1'b0;
    logic [2:0] ch;
    logic [7:0] dout;
    logic       dout_valid;
    logic       frame_err;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int valid_pulses = 0;

    tdm_demux8 #(.DW(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .sync       (sync),
        .din        (din),
        .err_clr    (err_clr),
        .ch         (ch),
        .dout       (dout),
        .dout_valid (dout_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference model: samples of the frame in progress held in a queue
    bit       m_in_frame = 0;
    bit       got[$];
    bit [7:0] m_dout = '0;
    bit       m_valid = 0;
    bit       m_err = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_in_frame = 0;
            got.delete();
            m_dout  = '0;
            m_valid = 0;
            m_err   = 0;
        end else begin
            m_valid = 0;
            if (err_clr) m_err = 0;
            if (en) begin
                if (sync) begin
                    if (m_in_frame && got.size() != 0) m_err = 1;
                    got.delete();
                    got.push_back(din[0]);
                    m_in_frame = 1;
                end else if (m_in_frame) begin
                    if (got.size() == 0) begin
                        m_err = 1;
                        m_in_frame = 0;
                    end else begin
                        got.push_back(din[0]);
                        if (got.size() == 8) begin
                            for (int i = 0; i < 8; i++) m_dout[i] = got[i];
                            m_valid = 1;
                            got.delete();
                        end
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model, away from the rising edge
    always @(negedge clk) begin
        check("ch",         {29'd0, ch},        32'(got.size()));
        check("dout",       {24'd0, dout},      {24'd0, m_dout});
        check("dout_valid", {31'd0, dout_valid}, {31'd0, m_valid});
        check("frame_err",  {31'd0, frame_err}, {31'd0, m_err});
        check("busy",       {31'd0, busy},      {31'd0, m_in_frame});
        if (dout_valid === 1'b1) valid_pulses++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic strobe(input bit s, input bit d);
        en = 1'b1;
        sync = s;
        din = d;
        @(posedge clk);
        #1;
        en = 1'b0;
        sync = 1'b0;
        din = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] v, input bit gaps);
        for (int i = 0; i < 8; i++) begin
            strobe(i == 0, v[i]);
            if (gaps && i != 7) idle(i % 4);
        end
    endtask

    initial begin
        #1 rst = 1'b1;
        idle(2);
        rst = 1'b0;
        idle(5);
        check("reset_ch",   {29'd0, ch}, 32'd0);
        check("reset_dout", {24'd0, dout}, 32'd0);
        check("reset_busy", {31'd0, busy}, 32'd0);

        // Single frame 1,0,1,1,0,0,1,0 -> 8'h4D one clock after the 8th edge
        send_frame(8'h4D, 0);
        check("f1_dout",  {24'd0, dout}, 32'h4D);
        check("f1_valid", {31'd0, dout_valid}, 32'd1);
        check("f1_ch",    {29'd0, ch}, 32'd0);
        check("f1_err",   {31'd0, frame_err}, 32'd0);
        idle(1);
        check("f1_valid_drop", {31'd0, dout_valid}, 32'd0);

        // Back-to-back frames with 0..3 idle cycles between strobes
        valid_pulses = 0;
        send_frame(8'h4D, 1);
        check("b2b_first", {24'd0, dout}, 32'h4D);
        send_frame(8'hB2, 1);
        check("b2b_second", {24'd0, dout}, 32'hB2);
        idle(2);
        check("b2b_pulses", 32'(valid_pulses), 32'd2);
        check("b2b_err", {31'd0, frame_err}, 32'd0);

        // Early sync on the 4th strobe: abort, then a full new frame
        valid_pulses = 0;
        strobe(1, 1); strobe(0, 1); strobe(0, 1);
        send_frame(8'h5A, 0);
        check("early_err",  {31'd0, frame_err}, 32'd1);
        check("early_dout", {24'd0, dout}, 32'h5A);
        idle(1);
        check("early_pulses", 32'(valid_pulses), 32'd1);

        // Clear alone
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        check("clr_alone", {31'd0, frame_err}, 32'd0);

        // Clear together with an early sync: error wins
        strobe(1, 0); strobe(0, 1);
        err_clr = 1'b1; strobe(1, 1); err_clr = 1'b0;
        check("clr_vs_err", {31'd0, frame_err}, 32'd1);
        strobe(0, 0); strobe(0, 1); strobe(0, 1); strobe(0, 0);
        strobe(0, 1); strobe(0, 0); strobe(0, 1);
        check("after_clr_frame", {24'd0, dout}, 32'hAD);

        // Lost sync at ch=0, then ignored strobes, then resync
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        strobe(0, 1);
        check("lost_err",  {31'd0, frame_err}, 32'd1);
        check("lost_busy", {31'd0, busy}, 32'd0);
        strobe(0, 1); strobe(0, 0);
        check("lost_ignored_ch", {29'd0, ch}, 32'd0);
        send_frame(8'h3C, 0);
        check("resync_dout", {24'd0, dout}, 32'h3C);

        // Asynchronous reset at ch=5
        strobe(1, 1); strobe(0, 1); strobe(0, 1); strobe(0, 1); strobe(0, 1);
        check("pre_rst_ch", {29'd0, ch}, 32'd5);
        #2 rst = 1'b1;
        #1;
        check("arst_ch",   {29'd0, ch}, 32'd0);
        check("arst_dout", {24'd0, dout}, 32'd0);
        check("arst_err",  {31'd0, frame_err}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        idle(1);
        rst = 1'b0;
        strobe(0, 1); strobe(0, 1); strobe(0, 1);
        idle(2);
        check("post_rst_dout", {24'd0, dout}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule : tb_tdm_demux8
`default_nettype wire
